// File: rtl/evaluate_collect_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : evaluate_collect_if                                             |
// | Brief    : Board/term collection bus between the evaluators and collector. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface evaluate_collect_if #(
    parameter int EVAL_WIDTH = 24,
    parameter int NUM_TERMS  = 8
);
    logic                            board_valid;
    logic                            clear_eval;
    logic [5:0]                      phase;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] term_mg;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] term_eg;
    logic [NUM_TERMS-1:0]            term_valid;
    logic [EVAL_WIDTH-1:0]           eval;
    logic                            eval_valid;

    modport master (
        output board_valid, clear_eval, phase, term_mg, term_eg, term_valid,
        input  eval, eval_valid
    );

    modport slave (
        input  board_valid, clear_eval, phase, term_mg, term_eg, term_valid,
        output eval, eval_valid
    );
endinterface
`default_nettype wire

// File: rtl/evaluate_collect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : evaluate_collect                                                |
// | Brief    : Collects per-evaluator mg/eg terms and produces a tapered eval. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module evaluate_collect #(
    parameter int EVAL_WIDTH = 24,
    parameter int NUM_TERMS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    evaluate_collect_if.slave bus
);
    localparam int c_SUM_W = EVAL_WIDTH + 4;
    localparam int c_T_W   = EVAL_WIDTH + 12;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_COLLECT = 3'd1;
    localparam logic [2:0] c_SUM     = 3'd2;
    localparam logic [2:0] c_TAPER   = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic signed [c_T_W-1:0] c_EVAL_MAX =
        {{(c_T_W-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
    localparam logic signed [c_T_W-1:0] c_EVAL_MIN =
        {{(c_T_W-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

    logic [2:0]                    r_state;
    logic [2:0]                    w_state_next;
    logic [NUM_TERMS-1:0]          r_flags;
    logic [NUM_TERMS-1:0]          w_capture;
    logic [5:0]                    r_phase;
    logic [5:0]                    w_phase_clamped;
    logic signed [EVAL_WIDTH-1:0]  r_mg [NUM_TERMS];
    logic signed [EVAL_WIDTH-1:0]  r_eg [NUM_TERMS];
    logic signed [c_SUM_W-1:0]     r_mg_sum;
    logic signed [c_SUM_W-1:0]     r_eg_sum;
    logic signed [c_SUM_W-1:0]     w_mg_sum;
    logic signed [c_SUM_W-1:0]     w_eg_sum;
    logic signed [6:0]             w_phase_mg;
    logic signed [6:0]             w_phase_eg;
    logic signed [c_T_W-1:0]       w_t;
    logic signed [c_T_W-1:0]       w_shift;
    logic [EVAL_WIDTH-1:0]         w_eval_sat;
    logic [EVAL_WIDTH-1:0]         r_eval;
    logic                          r_eval_valid;

    assign w_phase_clamped = (bus.phase > 6'd32) ? 6'd32 : bus.phase;

    // Next-state and per-term capture enables; board_valid outranks clear_eval.
    always_comb begin
        w_state_next = r_state;
        w_capture    = '0;
        if (bus.board_valid) begin
            w_state_next = c_COLLECT;
        end else if (bus.clear_eval) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_state_next = c_IDLE;
                end
                c_COLLECT: begin
                    w_capture = bus.term_valid & ~r_flags;
                    if (&(r_flags | w_capture)) begin
                        w_state_next = c_SUM;
                    end
                end
                c_SUM: begin
                    w_state_next = c_TAPER;
                end
                c_TAPER: begin
                    w_state_next = c_DONE;
                end
                c_DONE: begin
                    w_state_next = c_DONE;
                end
                default: begin
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_mg_sum = '0;
        w_eg_sum = '0;
        for (int k = 0; k < NUM_TERMS; k++) begin
            w_mg_sum = w_mg_sum + c_SUM_W'(r_mg[k]);
            w_eg_sum = w_eg_sum + c_SUM_W'(r_eg[k]);
        end
    end

    assign w_phase_mg = {1'b0, r_phase};
    assign w_phase_eg = 7'sd32 - w_phase_mg;
    assign w_t        = c_T_W'(r_mg_sum) * c_T_W'(w_phase_mg)
                      + c_T_W'(r_eg_sum) * c_T_W'(w_phase_eg);
    assign w_shift    = w_t >>> 5;

    always_comb begin
        if (w_shift > c_EVAL_MAX) begin
            w_eval_sat = c_EVAL_MAX[EVAL_WIDTH-1:0];
        end else if (w_shift < c_EVAL_MIN) begin
            w_eval_sat = c_EVAL_MIN[EVAL_WIDTH-1:0];
        end else begin
            w_eval_sat = w_shift[EVAL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_TERMS; k++) begin
                r_mg[k] <= '0;
                r_eg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_TERMS; k++) begin
                if (w_capture[k]) begin
                    r_mg[k] <= bus.term_mg[k*EVAL_WIDTH +: EVAL_WIDTH];
                    r_eg[k] <= bus.term_eg[k*EVAL_WIDTH +: EVAL_WIDTH];
                end
            end
        end
    end

    // The tapered total is shifted and saturated straight into the eval register
    // during TAPER so the result is already in place on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase      <= '0;
            r_flags      <= '0;
            r_mg_sum     <= '0;
            r_eg_sum     <= '0;
            r_eval       <= '0;
            r_eval_valid <= 1'b0;
        end else if (bus.board_valid) begin
            r_phase      <= w_phase_clamped;
            r_flags      <= '0;
            r_eval_valid <= 1'b0;
        end else if (bus.clear_eval) begin
            r_flags      <= '0;
            r_eval_valid <= 1'b0;
        end else begin
            r_flags <= r_flags | w_capture;
            if (r_state == c_SUM) begin
                r_mg_sum <= w_mg_sum;
                r_eg_sum <= w_eg_sum;
            end
            if (r_state == c_TAPER) begin
                r_eval       <= w_eval_sat;
                r_eval_valid <= 1'b1;
            end
        end
    end

    assign bus.eval       = r_eval;
    assign bus.eval_valid = r_eval_valid;
endmodule
`default_nettype wire

// File: doc/evaluate_collect.md
EVALUATE_COLLECT -- requirements
Module: evaluate_collect

Interface
REQ-001 Parameter: EVAL_WIDTH, default 24, signed width of every term and of the result.
REQ-002 Parameter: NUM_TERMS, default 8, number of evaluator terms combined; range 1..16.
REQ-003 Port: clk  input  1  single clock; all logic on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: board_valid  input  1  one-cycle pulse: new board presented to the evaluators; starts a collection.
REQ-006 Port: clear_eval  input  1  abort/clear the current evaluation.
REQ-007 Port: phase  input  6  game phase, 0 = pure endgame, 32 = pure middlegame; sampled on board_valid.
REQ-008 Port: term_mg  input  NUM_TERMS*EVAL_WIDTH  packed signed middlegame terms; term k is bits [k*EVAL_WIDTH +: EVAL_WIDTH].
REQ-009 Port: term_eg  input  NUM_TERMS*EVAL_WIDTH  packed signed endgame terms, same packing.
REQ-010 Port: term_valid  input  NUM_TERMS  per-term eval_valid from each evaluator.
REQ-011 Port: eval  output  EVAL_WIDTH  signed tapered total, registered.
REQ-012 Port: eval_valid  output  1  eval holds a complete result for the current board.

Function
REQ-013 The block SHALL implement states IDLE, COLLECT, SUM, TAPER, DONE.
REQ-014 board_valid in any state SHALL: latch phase (values >32 clamped to 32), clear all captured flags, clear eval_valid, and enter COLLECT next cycle; board_valid has priority over clear_eval.
REQ-015 In COLLECT, term k SHALL be captured (mg and eg) on the first cycle term_valid[k]=1 while its flag is clear; later assertions for the same board SHALL be ignored.
REQ-016 term_valid asserted on the same cycle as board_valid SHALL NOT be captured.
REQ-017 When all NUM_TERMS flags are set (including a flag set this cycle), the FSM SHALL move to SUM next cycle.
REQ-018 SUM SHALL register mg_sum and eg_sum as full-precision signed sums of width EVAL_WIDTH+4; no overflow is possible.
REQ-019 TAPER SHALL register t = mg_sum*phase + eg_sum*(32-phase) at full precision.
REQ-020 On entry to DONE, eval SHALL equal t arithmetically shifted right 5 (floor toward minus infinity), saturated to [-(2^(EVAL_WIDTH-1)), 2^(EVAL_WIDTH-1)-1], and eval_valid SHALL be 1.
REQ-021 Latency: eval_valid SHALL rise exactly 3 cycles after the cycle in which the last term is captured.
REQ-022 DONE SHALL hold eval and eval_valid until board_valid or clear_eval.
REQ-023 clear_eval (without board_valid) in any state SHALL force IDLE and eval_valid=0 next cycle; eval keeps its last value; captured flags cleared.
REQ-024 In IDLE, term_valid SHALL be ignored.

Reset
REQ-025 reset SHALL override all other inputs: state IDLE, eval=0, eval_valid=0, flags and latched phase cleared, internal sums 0.
REQ-026 reset asserted mid-collection SHALL discard all captured terms; no eval_valid pulse may follow it without a new board_valid.

Verification
REQ-027 NUM_TERMS=8, phase=32, all mg terms 10, eg 0, all term_valid on cycle 2 after board_valid -> eval=80, eval_valid rises 3 cycles after capture.
REQ-028 phase=16, mg sum 100, eg sum -41 -> t=(1600-656)=944, eval=29 (944>>5 floor); phase=0, eg sum -1 -> eval=-1 (floor).
REQ-029 Terms arrive staggered over 7 cycles, term 3 pulses twice with different values -> first value used; eval_valid 3 cycles after last new term.
REQ-030 EVAL_WIDTH=24, all eight mg terms +2^22, phase=32 -> eval saturates to 8388607; all -2^22 -> -8388608.
REQ-031 clear_eval during COLLECT with 5/8 terms captured, then remaining terms pulse -> eval_valid stays 0; new board_valid plus 8 terms -> correct result.
REQ-032 reset during TAPER -> eval=0, eval_valid=0 next cycle and no later eval_valid; board_valid and clear_eval on same cycle in DONE -> new collection starts.
